// File: rtl/scan_dff_pkg.sv
// rtl/scan_dff_pkg.sv - shared types and width helpers for the scan flip-flop bank
package scan_dff_pkg;

  // Configuration progress: nothing shifted, partially shifted, full word shifted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cfg_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Bits needed for a counter that must hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    int w;
    w = clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_dff_cell.sv
// rtl/scan_dff_cell.sv - one register bit with set/scan/load priority and async reset
module scan_dff_cell
  import scan_dff_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic shift,
  input  logic shift_in,
  input  logic load,
  input  logic d,
  output logic q
);

  // Set wins over scan, scan wins over functional load, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else if (set) begin
      q <= 1'b1;
    end else if (shift) begin
      q <= shift_in;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/scan_dff_bank.sv
// rtl/scan_dff_bank.sv - WIDTH-bit register bank with scan chain and config-done tracking
module scan_dff_bank
  import scan_dff_pkg::*;
#(
  parameter int              WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
  parameter bit              LOCK_UNTIL_CFG = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  input  logic             cfg_clr,
  output logic             cfg_done,
  output logic             cfg_overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q;

  // A shift only happens when set is not overriding it.
  logic shift_fire;
  logic load_ok;
  logic [WIDTH-1:0] chain_in;

  assign shift_fire = scan_en && !set;
  assign load_ok    = en && !(LOCK_UNTIL_CFG && !done_q);
  assign chain_in   = (WIDTH == 1) ? WIDTH'(scan_in) : {Q[WIDTH-2:0], scan_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    scan_dff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .set      (set),
      .shift    (scan_en),
      .shift_in (chain_in[i]),
      .load     (load_ok),
      .d        (D[i]),
      .q        (Q[i])
    );
  end

  // Next state: clear is applied first so a simultaneous shift counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (cfg_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
    if (shift_fire) begin
      case (state_d)
        IDLE: begin
          cnt_d   = CNT_W'(1);
          state_d = (WIDTH == 1) ? DONE : SHIFT;
        end
        SHIFT: begin
          state_d = (cnt_d == CNT_LAST) ? DONE : SHIFT;
          cnt_d   = cnt_d + CNT_W'(1);
        end
        DONE: begin
          ovf_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Counter, state and flags; cfg_done is its own flop so outputs stay pure register bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign scan_out     = Q[WIDTH-1];
  assign cfg_done     = done_q;
  assign cfg_overflow = ovf_q;

endmodule

// File: tb/tb_scan_dff_bank.sv
// tb/tb_scan_dff_bank.sv - scoreboard bench for scan_dff_bank, unlocked and locked variants
module tb_scan_dff_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       set = 1'b0;
  logic       scan_en = 1'b0;
  logic       scan_in = 1'b0;
  logic       en = 1'b0;
  logic       cfg_clr = 1'b0;
  logic [7:0] D = 8'h00;

  logic [7:0] q_free, q_lock;
  logic       so_free, so_lock, done_free, done_lock, ovf_free, ovf_lock;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  scan_dff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .LOCK_UNTIL_CFG(1'b0)) u_free (
    .clk(clk), .reset(reset), .set(set), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(so_free), .en(en), .D(D), .Q(q_free), .cfg_clr(cfg_clr),
    .cfg_done(done_free), .cfg_overflow(ovf_free)
  );

  scan_dff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .LOCK_UNTIL_CFG(1'b1)) u_lock (
    .clk(clk), .reset(reset), .set(set), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(so_lock), .en(en), .D(D), .Q(q_lock), .cfg_clr(cfg_clr),
    .cfg_done(done_lock), .cfg_overflow(ovf_lock)
  );

  typedef struct packed {
    logic [1:0][7:0] q;
    logic [1:0]      done;
    logic [1:0]      ovf;
  } exp_t;

  exp_t sb[$];

  // Reference model: register value as a number, count of shifts since clear, sticky overflow.
  int m_q[2];
  int m_cnt[2];
  bit m_ovf[2];

  function automatic exp_t snap();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.q[k]    = m_q[k][7:0];
      e.done[k] = (m_cnt[k] == 8);
      e.ovf[k]  = m_ovf[k];
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit s, input bit se, input bit si,
                                     input bit e, input int d, input bit c);
    for (int k = 0; k < 2; k++) begin
      bit configured;
      bit locked;
      configured = (m_cnt[k] == 8);
      locked = (k == 1) && !configured;
      if (s) m_q[k] = 255;
      else if (se) m_q[k] = ((m_q[k] * 2) + int'(si)) % 256;
      else if (e && !locked) m_q[k] = d;
      if (c) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end
      if (se && !s) begin
        if (m_cnt[k] == 8) m_ovf[k] = 1'b1;
        else m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endfunction

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%s] actual=%h required=%h at %0t", name, (k != 0) ? "lock" : "free", act, exp, $time);
  endtask

  task automatic check_all(input exp_t e);
    chk("Q",            0, q_free,            e.q[0]);
    chk("scan_out",     0, {7'b0, so_free},   {7'b0, e.q[0][7]});
    chk("cfg_done",     0, {7'b0, done_free}, {7'b0, e.done[0]});
    chk("cfg_overflow", 0, {7'b0, ovf_free},  {7'b0, e.ovf[0]});
    chk("Q",            1, q_lock,            e.q[1]);
    chk("scan_out",     1, {7'b0, so_lock},   {7'b0, e.q[1][7]});
    chk("cfg_done",     1, {7'b0, done_lock}, {7'b0, e.done[1]});
    chk("cfg_overflow", 1, {7'b0, ovf_lock},  {7'b0, e.ovf[1]});
  endtask

  // Monitor: outputs are stable by the falling edge after each active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) check_all(sb.pop_front());
  end

  task automatic step(input bit s, input bit se, input bit si, input bit e,
                      input logic [7:0] d, input bit c);
    set = s; scan_en = se; scan_in = si; en = e; D = d; cfg_clr = c;
    @(posedge clk);
    model_edge(s, se, si, e, int'(d), c);
    sb.push_back(snap());
    #1;
  endtask

  // Assert reset between edges and check outputs before any clock edge occurs.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all(snap());
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] bits;
    model_reset();
    #2;
    check_all(snap());
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Full configuration word, then an over-shift, then clear.
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, bits[7-i], 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Clear coinciding with a shift while DONE.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-shift with scan_en still high.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    scan_en = 1'b1;
    do_reset();

    // Lock mode: load ignored before configuration, honoured after.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);

    // Set together with scan and load after three shifts, then finish the word.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 19) == 0));
    end

    scan_en = 1'b0; en = 1'b0; set = 1'b0; cfg_clr = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
